// File: rtl/pll_lock_sequencer_if.sv
// Control/status and PLL-pin bundle for pll_lock_sequencer.
// start/stop are single-cycle pulses sampled on clk with no back-pressure; a start outside IDLE/RUN/FAIL is dropped.
interface pll_lock_sequencer_if;
  logic        start;
  logic        stop;
  logic [3:0]  cfg_prescale;
  logic        cfg_integer_mode;
  logic [10:0] cfg_mul_int;
  logic [11:0] cfg_mul_frac;
  logic        cfg_ssc_en;
  logic        cfg_ps0_en;
  logic        cfg_ps1_en;
  logic        pll_locked;
  logic        pll_rst_n;
  logic [3:0]  pll_prescale;
  logic        pll_integer_mode;
  logic [10:0] pll_mul_int;
  logic [11:0] pll_mul_frac;
  logic        pll_ssc_en;
  logic        pll_ps0_en;
  logic        pll_ps1_en;
  logic        ready;
  logic        busy;
  logic        fail;
  logic        lock_lost;
  logic [3:0]  retries;
  logic [2:0]  state;

  modport master (
    output start, stop, cfg_prescale, cfg_integer_mode, cfg_mul_int, cfg_mul_frac,
           cfg_ssc_en, cfg_ps0_en, cfg_ps1_en, pll_locked,
    input  pll_rst_n, pll_prescale, pll_integer_mode, pll_mul_int, pll_mul_frac,
           pll_ssc_en, pll_ps0_en, pll_ps1_en, ready, busy, fail, lock_lost, retries, state
  );

  modport slave (
    input  start, stop, cfg_prescale, cfg_integer_mode, cfg_mul_int, cfg_mul_frac,
           cfg_ssc_en, cfg_ps0_en, cfg_ps1_en, pll_locked,
    output pll_rst_n, pll_prescale, pll_integer_mode, pll_mul_int, pll_mul_frac,
           pll_ssc_en, pll_ps0_en, pll_ps1_en, ready, busy, fail, lock_lost, retries, state
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up and lock supervision: latch config, hold PLL in reset, wait for stable lock,
// enable outputs in RUN and retry a bounded number of times on timeout or loss of lock.
module pll_lock_sequencer #(
  parameter int RST_CYCLES   = 64,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  pll_lock_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET     = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_SETTLE    = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]       MAX_RETRY_C  = 4'(MAX_RETRY);

  logic             lock_meta, lock_s;
  state_t           state_q, state_n;
  logic [CNT_W-1:0] rst_cnt_q, rst_cnt_n;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_n;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_n;
  logic [3:0]       retries_q, retries_n;
  logic             lock_lost_q, lock_lost_n;
  logic             ssc_req_q, ps0_req_q, ps1_req_q;
  logic             accept_start, retry;

  always_comb begin
    state_n      = state_q;
    rst_cnt_n    = rst_cnt_q;
    to_cnt_n     = to_cnt_q;
    stab_cnt_n   = stab_cnt_q;
    retries_n    = retries_q;
    lock_lost_n  = lock_lost_q;
    accept_start = 1'b0;
    retry        = 1'b0;

    case (state_q)
      S_RESET: begin
        if (rst_cnt_q >= RST_LAST) state_n = S_WAIT_LOCK;
        else                       rst_cnt_n = rst_cnt_q + 1'b1;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_n    = S_SETTLE;
          stab_cnt_n = '0;
        end
      end
      S_SETTLE: begin
        if (!lock_s)                       state_n = S_WAIT_LOCK;
        else if (stab_cnt_q >= STABLE_LAST) state_n = S_RUN;
        else                               stab_cnt_n = stab_cnt_q + 1'b1;
      end
      S_RUN: begin
        if (!lock_s) begin
          lock_lost_n = 1'b1;
          retry       = 1'b1;
        end
      end
      default: ;
    endcase

    // A lock that completes on the timeout cycle still wins and enters RUN.
    if ((state_q == S_WAIT_LOCK || state_q == S_SETTLE) && state_n != S_RUN) begin
      if (to_cnt_q >= TIMEOUT_LAST) retry = 1'b1;
      else                          to_cnt_n = to_cnt_q + 1'b1;
    end

    if (retry) begin
      if (retries_q < MAX_RETRY_C) begin
        retries_n = retries_q + 1'b1;
        state_n   = S_RESET;
        rst_cnt_n = '0;
        to_cnt_n  = '0;
      end else begin
        state_n = S_FAIL;
      end
    end

    if (bus.start && (state_q == S_IDLE || state_q == S_FAIL || state_q == S_RUN)) begin
      accept_start = 1'b1;
      retries_n    = '0;
      lock_lost_n  = 1'b0;
      state_n      = S_RESET;
      rst_cnt_n    = '0;
      to_cnt_n     = '0;
    end

    // STOP overrides everything, including a retry or start in the same cycle.
    if (bus.stop) begin
      accept_start = 1'b0;
      state_n      = S_IDLE;
      retries_n    = retries_q;
      lock_lost_n  = lock_lost_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta            <= 1'b0;
      lock_s               <= 1'b0;
      state_q              <= S_IDLE;
      rst_cnt_q            <= '0;
      to_cnt_q             <= '0;
      stab_cnt_q           <= '0;
      retries_q            <= '0;
      lock_lost_q          <= 1'b0;
      ssc_req_q            <= 1'b0;
      ps0_req_q            <= 1'b0;
      ps1_req_q            <= 1'b0;
      bus.pll_prescale     <= '0;
      bus.pll_integer_mode <= 1'b0;
      bus.pll_mul_int      <= '0;
      bus.pll_mul_frac     <= '0;
      bus.pll_rst_n        <= 1'b0;
      bus.pll_ssc_en       <= 1'b0;
      bus.pll_ps0_en       <= 1'b0;
      bus.pll_ps1_en       <= 1'b0;
      bus.ready            <= 1'b0;
      bus.busy             <= 1'b0;
      bus.fail             <= 1'b0;
    end else begin
      lock_meta   <= bus.pll_locked;
      lock_s      <= lock_meta;
      state_q     <= state_n;
      rst_cnt_q   <= rst_cnt_n;
      to_cnt_q    <= to_cnt_n;
      stab_cnt_q  <= stab_cnt_n;
      retries_q   <= retries_n;
      lock_lost_q <= lock_lost_n;
      if (accept_start) begin
        bus.pll_prescale     <= bus.cfg_prescale;
        bus.pll_integer_mode <= bus.cfg_integer_mode;
        bus.pll_mul_int      <= bus.cfg_mul_int;
        bus.pll_mul_frac     <= bus.cfg_mul_frac;
        ssc_req_q            <= bus.cfg_ssc_en;
        ps0_req_q            <= bus.cfg_ps0_en;
        ps1_req_q            <= bus.cfg_ps1_en;
      end
      bus.pll_rst_n  <= (state_n == S_WAIT_LOCK) || (state_n == S_SETTLE) || (state_n == S_RUN);
      bus.ready      <= (state_n == S_RUN);
      bus.busy       <= (state_n == S_RESET) || (state_n == S_WAIT_LOCK) || (state_n == S_SETTLE);
      bus.fail       <= (state_n == S_FAIL);
      bus.pll_ssc_en <= (state_n == S_RUN) && ssc_req_q;
      bus.pll_ps0_en <= (state_n == S_RUN) && ps0_req_q;
      bus.pll_ps1_en <= (state_n == S_RUN) && ps1_req_q;
    end
  end

  assign bus.state     = state_q;
  assign bus.retries   = retries_q;
  assign bus.lock_lost = lock_lost_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: randomized configs and lock delays,
// expected timings computed from the sequencing rules by plain arithmetic.
module tb_pll_lock_sequencer;
  localparam int RST_CYCLES   = 4;
  localparam int LOCK_STABLE  = 8;
  localparam int LOCK_TIMEOUT = 32;
  localparam int MAX_RETRY    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pll_lock_sequencer_if bus();

  pll_lock_sequencer #(
    .RST_CYCLES  (RST_CYCLES),
    .LOCK_STABLE (LOCK_STABLE),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .MAX_RETRY   (MAX_RETRY),
    .CNT_W       (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard: config words expected to appear on the PLL pins after accepted STARTs
  logic [27:0] exp_q[$];
  logic [27:0] cur_cfg = '0;
  logic [2:0]  cur_req = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference timings from the sequencing rules
  function automatic int exp_ready_delay();
    return 2 + 1 + LOCK_STABLE;
  endfunction

  function automatic int exp_fail_delay();
    return (MAX_RETRY + 1) * (RST_CYCLES + LOCK_TIMEOUT);
  endfunction

  function automatic logic [27:0] dut_cfg();
    return {bus.pll_prescale, bus.pll_integer_mode, bus.pll_mul_int, bus.pll_mul_frac};
  endfunction

  function automatic logic [2:0] dut_en();
    return {bus.pll_ssc_en, bus.pll_ps0_en, bus.pll_ps1_en};
  endfunction

  function automatic logic [42:0] all_outs();
    return {bus.pll_rst_n, dut_cfg(), dut_en(), bus.ready, bus.busy, bus.fail,
            bus.lock_lost, bus.retries, bus.state};
  endfunction

  function automatic logic cond(input int sel);
    case (sel)
      0:       return bus.pll_rst_n;
      1:       return bus.ready;
      2:       return !bus.ready;
      3:       return bus.fail;
      default: return 1'b0;
    endcase
  endfunction

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_for(input int sel, input int budget, input string tag, output int n);
    n = 0;
    while (!cond(sel) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!cond(sel)) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic pulse(input logic st, input logic sp, input logic [27:0] cfg,
                       input logic [2:0] req, input bit accept);
    bus.start = st;
    bus.stop  = sp;
    {bus.cfg_prescale, bus.cfg_integer_mode, bus.cfg_mul_int, bus.cfg_mul_frac} = cfg;
    {bus.cfg_ssc_en, bus.cfg_ps0_en, bus.cfg_ps1_en} = req;
    if (accept) begin
      exp_q.push_back(cfg);
      cur_req = req;
    end
    tick(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic check_cfg(input string tag);
    if (exp_q.size() > 0) cur_cfg = exp_q.pop_front();
    check(tag, 64'(dut_cfg()), 64'(cur_cfg));
  endtask

  function automatic logic [27:0] rand_cfg();
    logic [27:0] c;
    c = 28'($urandom());
    return c;
  endfunction

  task automatic bring_up(input logic [27:0] cfg, input logic [2:0] req, input int d);
    int n;
    bus.pll_locked = 1'b0;
    pulse(1'b1, 1'b0, cfg, req, 1'b1);
    check("start_state", 64'(bus.state), 64'd1);
    check_cfg("start_cfg");
    wait_for(0, 50, "rst_rise", n);
    check("rst_low_cycles", 64'(n), 64'(RST_CYCLES));
    tick(d);
    bus.pll_locked = 1'b1;
    wait_for(1, 100, "ready_rise", n);
    check("ready_delay", 64'(n), 64'(exp_ready_delay()));
    check("run_enables", 64'(dut_en()), 64'(cur_req));
    check("run_retries", 64'(bus.retries), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    int d;
    logic [27:0] c;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.cfg_prescale = '0;
    bus.cfg_integer_mode = 1'b0;
    bus.cfg_mul_int = '0;
    bus.cfg_mul_frac = '0;
    bus.cfg_ssc_en = 1'b0;
    bus.cfg_ps0_en = 1'b0;
    bus.cfg_ps1_en = 1'b0;
    bus.pll_locked = 1'b0;

    // reset state
    tick(3);
    check("reset_outputs", 64'(all_outs()), 64'd0);
    rst = 1'b0;
    tick(2);
    check("idle_outputs", 64'(all_outs()), 64'd0);

    // nominal bring-up, lock 10 cycles after PLL reset release
    c = rand_cfg();
    c[22:12] = 11'h064;
    bring_up(c, 3'b111, 10);
    check("mul_int", 64'(bus.pll_mul_int), 64'h064);

    // randomized re-starts from RUN
    for (int i = 0; i < 3; i++) begin
      bring_up(rand_cfg(), 3'($urandom_range(0, 7)), $urandom_range(1, 10));
    end

    // single-cycle lock glitch in SETTLE
    bus.pll_locked = 1'b0;
    pulse(1'b1, 1'b0, rand_cfg(), 3'b101, 1'b1);
    check_cfg("glitch_cfg");
    wait_for(0, 50, "glitch_rst_rise", n);
    tick($urandom_range(1, 10));
    bus.pll_locked = 1'b1;
    tick(5);
    bus.pll_locked = 1'b0;
    tick(1);
    bus.pll_locked = 1'b1;
    tick(2);
    check("glitch_wait_lock", 64'(bus.state), 64'd2);
    check("glitch_retries", 64'(bus.retries), 64'd0);
    wait_for(1, 100, "glitch_ready", n);
    check("glitch_ready_delay", 64'(n), 64'(exp_ready_delay() - 2));
    check("glitch_enables", 64'(dut_en()), 64'(cur_req));

    // exhausted retries with no lock
    bus.pll_locked = 1'b0;
    pulse(1'b1, 1'b0, rand_cfg(), 3'b111, 1'b1);
    check_cfg("exhaust_cfg");
    tick(RST_CYCLES + LOCK_TIMEOUT + 1);
    check("exhaust_retry1", 64'(bus.retries), 64'd1);
    check("exhaust_retry1_state", 64'(bus.state), 64'd1);
    wait_for(3, 400, "fail_rise", n);
    check("fail_delay", 64'(n + RST_CYCLES + LOCK_TIMEOUT + 1), 64'(exp_fail_delay()));
    check("fail_retries", 64'(bus.retries), 64'(MAX_RETRY));
    check("fail_pins", 64'({bus.pll_rst_n, dut_en(), bus.ready, bus.busy}), 64'd0);

    // loss of lock in RUN
    bring_up(rand_cfg(), 3'b111, $urandom_range(1, 10));
    bus.pll_locked = 1'b0;
    wait_for(2, 20, "loss_ready_fall", n);
    check("loss_delay", 64'(n), 64'd3);
    check("loss_enables", 64'(dut_en()), 64'd0);
    check("loss_lock_lost", 64'(bus.lock_lost), 64'd1);
    check("loss_retries", 64'(bus.retries), 64'd1);
    wait_for(0, 50, "loss_rst_rise", n);
    tick($urandom_range(1, 10));
    bus.pll_locked = 1'b1;
    wait_for(1, 100, "relock_ready", n);
    check("relock_delay", 64'(n), 64'(exp_ready_delay()));
    check("relock_lock_lost", 64'(bus.lock_lost), 64'd1);
    check("relock_retries", 64'(bus.retries), 64'd1);

    // START and STOP together in RUN: STOP wins, config untouched
    pulse(1'b1, 1'b1, rand_cfg(), 3'b000, 1'b0);
    check("startstop_state", 64'(bus.state), 64'd0);
    check("startstop_pins", 64'({bus.pll_rst_n, bus.ready, dut_en()}), 64'd0);
    check_cfg("startstop_cfg");
    check("startstop_lock_lost", 64'(bus.lock_lost), 64'd1);
    check("startstop_retries", 64'(bus.retries), 64'd1);

    bus.pll_locked = 1'b0;
    c = rand_cfg();
    c[11:0] = 12'hABC;
    pulse(1'b1, 1'b0, c, 3'b011, 1'b1);
    check("frac_latched", 64'(bus.pll_mul_frac), 64'hABC);
    check_cfg("frac_cfg");
    check("frac_lock_lost", 64'(bus.lock_lost), 64'd0);
    check("frac_retries", 64'(bus.retries), 64'd0);

    // asynchronous reset in the middle of SETTLE
    wait_for(0, 50, "settle_rst_rise", n);
    tick($urandom_range(1, 10));
    bus.pll_locked = 1'b1;
    tick(5);
    check("settle_state", 64'(bus.state), 64'd3);
    #3 rst = 1'b1;
    #1;
    check("async_reset_outputs", 64'(all_outs()), 64'd0);
    cur_cfg = '0;
    bus.pll_locked = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(1);
    check_cfg("post_reset_cfg");
    bring_up(rand_cfg(), 3'($urandom_range(0, 7)), $urandom_range(1, 10));

    // plain STOP from RUN
    pulse(1'b0, 1'b1, rand_cfg(), 3'b111, 1'b0);
    check("stop_state", 64'(bus.state), 64'd0);
    check("stop_pins", 64'({bus.pll_rst_n, bus.ready, dut_en()}), 64'd0);
    check_cfg("stop_cfg");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
